instr_fetch_decode: RTL

Fetch/decode stage directly upstream of the control unit. Reads opcode and operand bytes from program ROM, decodes the supported 8051-style instruction subset into the control unit's field bundle (ALU_opcode, opcode_length, operand1/2, R, SP_PUSH, SP_POP, ALU_MEMORY, RIDIR) plus immediate bytes, and holds each decoded instruction under a valid/ready handshake. Owns the architectural PC, LJMP and external redirects.

---
 rtl/instr_fetch_decode.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: reads opcode/operand bytes from program ROM, decodes the 8051-style subset
// and holds each instruction under valid/ready. ILLEGAL_TRAP_EN enables the illegal-opcode halt.
module instr_fetch_decode #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] rom_addr,
    output logic        rom_re,
    input  logic [7:0]  rom_data,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [4:0]  ALU_opcode,
    output logic [1:0]  opcode_length,
    output logic [1:0]  operand1,
    output logic [1:0]  operand2,
    output logic [2:0]  R,
    output logic        SP_PUSH,
    output logic        SP_POP,
    output logic        ALU_MEMORY,
    output logic        RIDIR,
    output logic [7:0]  imm1,
    output logic [7:0]  imm2,
    output logic [15:0] pc_out,
    output logic        illegal,
    output logic [2:0]  dbg_state
);

    // Handshake: an instruction transfers on a rising edge where dec_valid && dec_ready;
    // dec_valid never drops and fields never change while waiting, except on redirect or reset.
    typedef enum logic [2:0] {S_OP, S_DEC, S_B1, S_B2, S_ISSUE, S_HALT} state_t;

    typedef struct packed {
        logic [4:0] alu_op;
        logic [1:0] len;
        logic [1:0] op1;
        logic [1:0] op2;
        logic [2:0] r;
        logic       push;
        logic       pop;
        logic       mem;
        logic       ridir;
    } dec_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    dec_t        dec_q, dec_d, dec_c;
    logic [7:0]  op_q, op_d, imm1_q, imm1_d, imm2_q, imm2_d;
    logic        legal_c, grp_hit, rom_re_c, illegal_c;
    logic [4:0]  grp_op;

    // Decode of the byte currently on rom_data (meaningful in S_DEC).
    always_comb begin
        dec_c   = '0;
        legal_c = 1'b1;
        grp_hit = 1'b1;
        grp_op  = 5'd0;
        case (rom_data[7:4])
            4'h2:    grp_op = 5'd0;
            4'h3:    grp_op = 5'd1;
            4'h9:    grp_op = 5'd2;
            4'h5:    grp_op = 5'd3;
            4'h4:    grp_op = 5'd4;
            4'h6:    grp_op = 5'd5;
            default: grp_hit = 1'b0;
        endcase
        if (grp_hit && rom_data[3:2] != 2'b00) begin
            dec_c.alu_op = grp_op;
            dec_c.op1    = 2'd1;
            if (rom_data[3]) begin
                dec_c.len = 2'd1;
                dec_c.r   = rom_data[2:0];
            end else if (rom_data[1]) begin
                dec_c.len   = 2'd1;
                dec_c.ridir = 1'b1;
                dec_c.r     = {2'b00, rom_data[0]};
            end else begin
                dec_c.len = 2'd2;
                dec_c.op2 = rom_data[0] ? 2'd3 : 2'd2;
            end
        end else begin
            casez (rom_data)
                8'h00: dec_c.len = 2'd1;
                8'h02: dec_c.len = 2'd3;
                8'h04: begin dec_c.alu_op = 5'd6; dec_c.len = 2'd1; dec_c.op1 = 2'd1; dec_c.op2 = 2'd1; end
                8'h14: begin dec_c.alu_op = 5'd7; dec_c.len = 2'd1; dec_c.op1 = 2'd1; dec_c.op2 = 2'd1; end
                8'h74: begin dec_c.alu_op = 5'd8; dec_c.len = 2'd2; dec_c.op1 = 2'd1; dec_c.op2 = 2'd2; dec_c.mem = 1'b1; end
                8'b1110_1???: begin
                    dec_c.alu_op = 5'd8; dec_c.len = 2'd1; dec_c.op1 = 2'd1;
                    dec_c.r = rom_data[2:0]; dec_c.mem = 1'b1;
                end
                8'b1111_1???: begin
                    dec_c.alu_op = 5'd8; dec_c.len = 2'd1; dec_c.op2 = 2'd1;
                    dec_c.r = rom_data[2:0]; dec_c.mem = 1'b1;
                end
                8'b0111_1???: begin
                    dec_c.alu_op = 5'd8; dec_c.len = 2'd2; dec_c.op2 = 2'd2;
                    dec_c.r = rom_data[2:0]; dec_c.mem = 1'b1;
                end
                8'hC0: begin dec_c.alu_op = 5'd8; dec_c.len = 2'd2; dec_c.op1 = 2'd3; dec_c.push = 1'b1; dec_c.mem = 1'b1; end
                8'hD0: begin dec_c.alu_op = 5'd8; dec_c.len = 2'd2; dec_c.op1 = 2'd3; dec_c.pop = 1'b1; dec_c.mem = 1'b1; end
                default: legal_c = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        dec_d     = dec_q;
        op_d      = op_q;
        imm1_d    = imm1_q;
        imm2_d    = imm2_q;
        rom_re_c  = 1'b0;
        rom_addr  = pc_q;
        illegal_c = 1'b0;
        if (redirect_en) begin
            pc_d    = redirect_pc;
            state_d = S_OP;
        end else begin
            case (state_q)
                S_OP: begin
                    rom_re_c = 1'b1;
                    state_d  = S_DEC;
                end
                S_DEC: begin
`ifdef ILLEGAL_TRAP_EN
                    if (!legal_c) begin
                        illegal_c = 1'b1;
                        state_d   = S_HALT;
                    end else if (rom_data == 8'h00) begin
`else
                    if (!legal_c || rom_data == 8'h00) begin
`endif
                        pc_d    = pc_q + 16'd1;
                        state_d = S_OP;
                    end else begin
                        dec_d  = dec_c;
                        op_d   = rom_data;
                        imm1_d = 8'h00;
                        imm2_d = 8'h00;
                        if (dec_c.len == 2'd1) begin
                            state_d = S_ISSUE;
                        end else begin
                            rom_re_c = 1'b1;
                            rom_addr = pc_q + 16'd1;
                            state_d  = S_B1;
                        end
                    end
                end
                S_B1: begin
                    imm1_d = rom_data;
                    if (dec_q.len == 2'd3) begin
                        rom_re_c = 1'b1;
                        rom_addr = pc_q + 16'd2;
                        state_d  = S_B2;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_B2: begin
                    imm2_d = rom_data;
                    if (op_q == 8'h02) begin
                        pc_d    = {imm1_q, rom_data};
                        state_d = S_OP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (dec_ready) begin
                        pc_d    = pc_q + {14'd0, dec_q.len};
                        state_d = S_OP;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_OP;
            pc_q    <= RESET_PC;
            dec_q   <= '0;
            op_q    <= 8'h00;
            imm1_q  <= 8'h00;
            imm2_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dec_q   <= dec_d;
            op_q    <= op_d;
            imm1_q  <= imm1_d;
            imm2_q  <= imm2_d;
        end
    end

    // The async reset also masks the read strobe, since S_OP is the reset state.
    assign rom_re        = rom_re_c & reset;
    assign dec_valid     = (state_q == S_ISSUE);
    assign ALU_opcode    = dec_q.alu_op;
    assign opcode_length = dec_q.len;
    assign operand1      = dec_q.op1;
    assign operand2      = dec_q.op2;
    assign R             = dec_q.r;
    assign SP_PUSH       = dec_q.push;
    assign SP_POP        = dec_q.pop;
    assign ALU_MEMORY    = dec_q.mem;
    assign RIDIR         = dec_q.ridir;
    assign imm1          = imm1_q;
    assign imm2          = imm2_q;
    assign pc_out        = pc_q;
    assign dbg_state     = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal       = illegal_c;
`else
    assign illegal       = 1'b0;
    logic unused_illegal;
    assign unused_illegal = illegal_c;
`endif

endmodule
